// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
//   Shared definitions for the LCD digit renderer and the LCD serial driver:
//   renderer FSM states, glyph ROM geometry, frame RAM geometry and the
//   shank_position -> picture slot decode.
// ---------------------------------------------------------------------------
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FETCH,
    ST_WRITE,
    ST_DONE
  } state_t;

  // Glyph ROM geometry: 17 glyphs (0-F hex digits plus a blank), each 8 columns
  // wide and two 8-pixel pages tall, stored as 16 consecutive bytes.
  localparam int unsigned GLYPH_BLANK = 16;
  localparam int unsigned GLYPH_W     = 8;
  localparam int unsigned GLYPH_BYTES = 16;

  // Frame RAM geometry: six 1 KB picture slots of 8 pages x 128 columns.
  localparam int unsigned SLOT_BYTES  = 1024;
  localparam int unsigned PAGE_BYTES  = 128;

  localparam int unsigned NUM_DIGITS  = 5;

  typedef logic [4:0] glyph_t;

  // One-hot shank position to picture slot; anything not one-hot selects 5.
  function automatic logic [2:0] slot_of(input logic [5:0] shank);
    logic [2:0] slot;
    case (shank)
      6'b000001: slot = 3'd5;
      6'b000010: slot = 3'd4;
      6'b000100: slot = 3'd3;
      6'b001000: slot = 3'd2;
      6'b010000: slot = 3'd1;
      6'b100000: slot = 3'd0;
      default:   slot = 3'd5;
    endcase
    return slot;
  endfunction

  // Glyph ROM byte address for glyph g, page half h, column c.
  function automatic logic [8:0] font_addr_of(input glyph_t g, input logic h,
                                              input logic [2:0] c);
    return 9'(g) * 9'(GLYPH_BYTES) + 9'(h) * 9'(GLYPH_W) + 9'(c);
  endfunction

endpackage

// File: rtl/lcd_lz_blank.sv
// ---------------------------------------------------------------------------
// lcd_lz_blank
//   Combinational glyph selection for the five displayed digits, including
//   optional leading-zero blanking.
//   Ports:
//     i_num    [19:0]  five nibbles, [19:16] leftmost digit
//     o_glyph  5x5     glyph index per digit, index 0 = leftmost digit
//   Parameter:
//     BLANK_LZ  when 1, zero digits with only zeros to their left become blank;
//               the rightmost digit is always drawn.
// ---------------------------------------------------------------------------
module lcd_lz_blank
  import lcd_pkg::*;
#(
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic [19:0]                 i_num,
  output glyph_t [NUM_DIGITS-1:0]     o_glyph
);

  logic [3:0] w_nib;
  logic       w_lead;

  always_comb begin
    o_glyph = '0;
    w_nib   = '0;
    w_lead  = 1'b1;
    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      w_nib  = i_num[4*(NUM_DIGITS-1-d) +: 4];
      // w_lead stays set only while every digit so far (left to right) is zero
      w_lead = w_lead & (w_nib == 4'h0);
      if (BLANK_LZ && (d < NUM_DIGITS - 1) && w_lead) begin
        o_glyph[d] = 5'(GLYPH_BLANK);
      end else begin
        o_glyph[d] = {1'b0, w_nib};
      end
    end
  end

endmodule

// File: rtl/lcd_digit_renderer.sv
// ---------------------------------------------------------------------------
// lcd_digit_renderer
//   Renders a 5-digit hex value as 8x16 glyphs into the picture slot of the
//   frame RAM selected by shank_position. A new render starts whenever the
//   number or slot differs from the last rendered snapshot (or after reset).
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     number_on_digitron  five nibbles, [19:16] leftmost
//     shank_position      one-hot slot select
//     font_addr/font_q    glyph ROM port, data valid one cycle after address
//     wr_en/wr_addr/wr_data  frame RAM write port
//     busy                high from LOAD through DONE
//     frame_done          one-cycle pulse after the 80th byte
//   Parameters:
//     PAGE0     first LCD page of the digit row (digits use PAGE0, PAGE0+1)
//     COL0      first column of the leftmost digit (COL0+40 <= 128)
//     BLANK_LZ  blank leading zero digits
// ---------------------------------------------------------------------------
module lcd_digit_renderer
  import lcd_pkg::*;
#(
  parameter int unsigned PAGE0    = 6,
  parameter int unsigned COL0     = 44,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] number_on_digitron,
  input  logic [5:0]  shank_position,
  output logic [8:0]  font_addr,
  input  logic [7:0]  font_q,
  output logic        wr_en,
  output logic [12:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic        frame_done
);

  state_t                   r_state;
  logic [19:0]              r_snap_num;
  logic [2:0]               r_snap_slot;
  logic                     r_snap_valid;
  glyph_t [NUM_DIGITS-1:0]  r_glyph;

  // Byte cursor: digit, page half, column
  logic [2:0]               r_d;
  logic                     r_h;
  logic [2:0]               r_c;

  logic [8:0]               r_font_addr;
  logic                     r_wr_en;
  logic [12:0]              r_wr_addr;
  logic                     r_busy;
  logic                     r_frame_done;

  logic [2:0]               w_slot;
  logic                     w_dirty;
  glyph_t [NUM_DIGITS-1:0]  w_glyph;
  logic [2:0]               w_nd;
  logic                     w_nh;
  logic [2:0]               w_nc;
  logic                     w_last;
  logic [12:0]              w_wr_addr;

  assign w_slot  = slot_of(shank_position);
  assign w_dirty = !r_snap_valid
                || (number_on_digitron != r_snap_num)
                || (w_slot != r_snap_slot);

  lcd_lz_blank #(
    .BLANK_LZ (BLANK_LZ)
  ) u_lz_blank (
    .i_num   (number_on_digitron),
    .o_glyph (w_glyph)
  );

  // Next cursor position: column fastest, then page half, then digit.
  always_comb begin
    w_nc = r_c + 3'd1;
    w_nh = r_h;
    w_nd = r_d;
    if (r_c == 3'd7) begin
      w_nh = ~r_h;
      if (r_h) begin
        w_nd = r_d + 3'd1;
      end
    end
  end

  assign w_last = (r_d == 3'(NUM_DIGITS - 1)) && r_h && (r_c == 3'd7);

  assign w_wr_addr = 13'(r_snap_slot) * 13'(SLOT_BYTES)
                   + (13'(PAGE0) + 13'(r_h)) * 13'(PAGE_BYTES)
                   + 13'(COL0)
                   + 13'(r_d) * 13'(GLYPH_W)
                   + 13'(r_c);

  // Outputs are registered one transition ahead of the state they belong to:
  // font_addr is loaded on entry to FETCH so the ROM byte is ready in WRITE,
  // and wr_en/wr_addr are loaded on entry to WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_snap_num   <= '0;
      r_snap_slot  <= '0;
      r_snap_valid <= 1'b0;
      r_glyph      <= '0;
      r_d          <= '0;
      r_h          <= 1'b0;
      r_c          <= '0;
      r_font_addr  <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_wr_en      <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_dirty) begin
            r_busy  <= 1'b1;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_snap_num   <= number_on_digitron;
          r_snap_slot  <= w_slot;
          r_snap_valid <= 1'b1;
          r_glyph      <= w_glyph;
          r_d          <= '0;
          r_h          <= 1'b0;
          r_c          <= '0;
          // r_glyph is not loaded yet, so the first fetch uses the live decode
          r_font_addr  <= font_addr_of(w_glyph[0], 1'b0, 3'd0);
          r_state      <= ST_FETCH;
        end
        ST_FETCH: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= w_wr_addr;
          r_state   <= ST_WRITE;
        end
        ST_WRITE: begin
          if (w_last) begin
            r_frame_done <= 1'b1;
            r_state      <= ST_DONE;
          end else begin
            r_d         <= w_nd;
            r_h         <= w_nh;
            r_c         <= w_nc;
            r_font_addr <= font_addr_of(r_glyph[w_nd], w_nh, w_nc);
            r_state     <= ST_FETCH;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign font_addr  = r_font_addr;
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  // ROM data arrives during WRITE; gate it so the port reads zero otherwise
  assign wr_data    = r_wr_en ? font_q : '0;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_lcd_digit_renderer.sv
// ---------------------------------------------------------------------------
// tb_lcd_digit_renderer
//   Two renderers (leading-zero blanking on and off) share inputs. A reference
//   model predicts every frame from the render rules and pushes the expected
//   writes into per-instance queues; a monitor pops and compares each write.
// ---------------------------------------------------------------------------
module tb_lcd_digit_renderer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [19:0] number;
  logic [5:0]  shank;

  logic [8:0]  fa0, fa1;
  logic [7:0]  fq0, fq1;
  logic        we0, we1;
  logic [12:0] wa0, wa1;
  logic [7:0]  wd0, wd1;
  logic        bz0, bz1;
  logic        fd0, fd1;

  lcd_digit_renderer #(.PAGE0(6), .COL0(44), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .number_on_digitron(number), .shank_position(shank),
    .font_addr(fa0), .font_q(fq0), .wr_en(we0), .wr_addr(wa0), .wr_data(wd0),
    .busy(bz0), .frame_done(fd0));

  lcd_digit_renderer #(.PAGE0(6), .COL0(44), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .number_on_digitron(number), .shank_position(shank),
    .font_addr(fa1), .font_q(fq1), .wr_en(we1), .wr_addr(wa1), .wr_data(wd1),
    .busy(bz1), .frame_done(fd1));

  always #5 clk = ~clk;

  // Glyph ROM with random contents, one cycle read latency
  logic [7:0] rom [512];
  always @(posedge clk) begin
    fq0 <= rom[fa0];
    fq1 <= rom[fa1];
  end

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     addr;
    int     fa;
    int     data;
    longint cyc;
  } exp_t;

  exp_t   q0[$], q1[$];
  longint dq0[$], dq1[$];

  int checks = 0;
  int errors = 0;
  int n_wr0 = 0;
  int n_fd0 = 0;

  // Reference model state
  bit          m_idle = 1'b1;
  bit          m_sv = 1'b0;
  int          m_t = 0;
  logic [19:0] m_snum = '0;
  int          m_sslot = 0;

  function automatic int ref_slot(input logic [5:0] s);
    if ($countones(s) != 1) return 5;
    for (int i = 0; i < 6; i++) if (s[i]) return 5 - i;
    return 5;
  endfunction

  function automatic int nib_of(input logic [19:0] num, input int d);
    return int'((num >> (4 * (4 - d))) & 20'hF);
  endfunction

  function automatic int ref_glyph(input logic [19:0] num, input int d, input bit blz);
    bit all0;
    all0 = 1'b1;
    for (int k = 0; k <= d; k++) if (nib_of(num, k) != 0) all0 = 1'b0;
    if (blz && d < 4 && all0) return 16;
    return nib_of(num, d);
  endfunction

  function automatic bit ref_dirty();
    return !m_sv || (number != m_snum) || (ref_slot(shank) != m_sslot);
  endfunction

  // Expected frame: 80 writes, digit-major then page half then column,
  // one write every second cycle starting two cycles after the load cycle.
  task automatic push_frame(input logic [19:0] num, input int slot, input longint ld);
    exp_t e;
    int   k;
    k = 0;
    for (int d = 0; d < 5; d++)
      for (int h = 0; h < 2; h++)
        for (int c = 0; c < 8; c++) begin
          e.addr = slot * 1024 + (6 + h) * 128 + 44 + d * 8 + c;
          e.cyc  = ld + 2 + 2 * k;
          e.fa   = ref_glyph(num, d, 1'b1) * 16 + h * 8 + c;
          e.data = int'(rom[e.fa]);
          q0.push_back(e);
          e.fa   = ref_glyph(num, d, 1'b0) * 16 + h * 8 + c;
          e.data = int'(rom[e.fa]);
          q1.push_back(e);
          k++;
        end
    dq0.push_back(ld + 161);
    dq1.push_back(ld + 161);
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_idle = 1'b1;
        m_sv   = 1'b0;
        q0.delete(); q1.delete(); dq0.delete(); dq1.delete();
      end else if (m_idle) begin
        if (ref_dirty()) begin
          m_idle = 1'b0;
          m_t    = 0;
        end
      end else begin
        if (m_t == 0) begin
          m_snum  = number;
          m_sslot = ref_slot(shank);
          m_sv    = 1'b1;
          push_frame(number, m_sslot, cyc);
        end
        if (m_t == 161) m_idle = 1'b1;
        else m_t++;
      end
    end
  end

  task automatic mon(input int i, input logic we, input logic [12:0] wa, input logic [7:0] wd,
                     input logic [8:0] pfa, input logic bz, input logic fd);
    exp_t   e;
    longint dc;
    bit     have;
    checks++;
    if (bz !== !m_idle) begin
      errors++;
      $display("FAIL busy[%0d] cyc=%0d: got %b want %b", i, cyc, bz, !m_idle);
    end
    if (we !== 1'b0) begin
      checks++;
      have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (we !== 1'b1 || !have) begin
        errors++;
        $display("FAIL write[%0d] cyc=%0d: got wr_en=%b addr=%0d, want no write", i, cyc, we, wa);
      end else begin
        if (i == 0) begin e = q0.pop_front(); n_wr0++; end
        else e = q1.pop_front();
        if (wa !== 13'(e.addr) || wd !== 8'(e.data) || pfa !== 9'(e.fa) || cyc != e.cyc) begin
          errors++;
          $display("FAIL write[%0d]: got addr=%0d data=%02h font=%0d cyc=%0d, want addr=%0d data=%02h font=%0d cyc=%0d",
                   i, wa, wd, pfa, cyc, e.addr, e.data, e.fa, e.cyc);
        end
      end
    end
    if (fd !== 1'b0) begin
      checks++;
      have = (i == 0) ? (dq0.size() > 0) : (dq1.size() > 0);
      if (fd !== 1'b1 || !have) begin
        errors++;
        $display("FAIL frame_done[%0d] cyc=%0d: got %b, want 0", i, cyc, fd);
      end else begin
        if (i == 0) begin dc = dq0.pop_front(); n_fd0++; end
        else dc = dq1.pop_front();
        if (cyc != dc) begin
          errors++;
          $display("FAIL frame_done[%0d]: got cyc=%0d want cyc=%0d", i, cyc, dc);
        end
      end
    end
  endtask

  logic [8:0] pfa0 = '0, pfa1 = '0;
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      mon(0, we0, wa0, wd0, pfa0, bz0, fd0);
      mon(1, we1, wa1, wd1, pfa1, bz1, fd1);
      pfa0 = fa0;
      pfa1 = fa1;
    end
  end

  task automatic chk_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({we0, bz0, fd0, fa0, wa0, wd0} !== '0) begin
      errors++;
      $display("FAIL %s[0]: got en=%b busy=%b done=%b fa=%0d wa=%0d wd=%0d, want all 0",
               name, we0, bz0, fd0, fa0, wa0, wd0);
    end
    checks++;
    if ({we1, bz1, fd1, fa1, wa1, wd1} !== '0) begin
      errors++;
      $display("FAIL %s[1]: got en=%b busy=%b done=%b fa=%0d wa=%0d wd=%0d, want all 0",
               name, we1, bz1, fd1, fa1, wa1, wd1);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_quiet(input string name);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (m_idle && !ref_dirty() && q0.size() == 0 && q1.size() == 0 &&
          dq0.size() == 0 && dq1.size() == 0) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: got no quiet idle within 3000 cycles, want render complete", name);
  endtask

  task automatic wait_writes(input string name, input int target);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (n_wr0 >= target) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: got %0d writes want %0d within 1000 cycles", name, n_wr0, target);
  endtask

  function automatic logic [19:0] rand_num();
    logic [31:0] v;
    int          z;
    v = $urandom;
    z = $urandom_range(0, 5);
    if (z == 5) return '0;
    return 20'(v & ((32'd1 << (4 * (5 - z))) - 1));
  endfunction

  function automatic logic [5:0] rand_shank();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return 6'(1 << r);
    if (r == 6) return 6'b000000;
    return 6'($urandom);
  endfunction

  int f0, w0;
  logic [19:0] old_num;

  initial begin
    for (int i = 0; i < 512; i++) rom[i] = 8'($urandom);
    number = 20'h00042;
    shank  = 6'b100000;
    #1 rst_n = 1'b0;
    tick(3);
    check_zero("reset_state");

    // Full render after reset release
    f0 = n_fd0; w0 = n_wr0;
    rst_n = 1'b1;
    wait_quiet("t1");
    chk_int("t1_frames", n_fd0 - f0, 1);
    chk_int("t1_writes", n_wr0 - w0, 80);

    // Slot change only
    number = 20'h12345; shank = 6'b000001;
    wait_quiet("t2a");
    f0 = n_fd0;
    shank = 6'b000100;
    wait_quiet("t2b");
    chk_int("t2_frames", n_fd0 - f0, 1);

    // Number change mid-frame gives exactly one follow-up render
    f0 = n_fd0;
    number = 20'h0A0F3;
    wait_writes("t3", n_wr0 + 40);
    number = 20'h00007;
    wait_quiet("t3");
    chk_int("t3_frames", n_fd0 - f0, 2);

    // All zeros: blanking differs between the two instances
    number = 20'h00000;
    wait_quiet("t4");

    // Asynchronous reset mid-frame
    number = 20'h00310;
    tick(1);
    wait_writes("t5", n_wr0 + 17);
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    tick(2);
    f0 = n_fd0; w0 = n_wr0;
    rst_n = 1'b1;
    wait_quiet("t5");
    chk_int("t5_frames", n_fd0 - f0, 1);
    chk_int("t5_writes", n_wr0 - w0, 80);

    // Zero-hot and multi-hot both decode to slot 5
    shank = 6'b000000;
    wait_quiet("t6a");
    f0 = n_fd0;
    shank = 6'b011000;
    tick(5);
    wait_quiet("t6b");
    chk_int("t6_no_rerender", n_fd0 - f0, 0);

    // Randomized input changes, including during renders and short toggles
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: number = rand_num();
        1: shank = rand_shank();
        2: begin number = rand_num(); shank = rand_shank(); end
        default: begin
          old_num = number;
          number = number ^ 20'h00001;
          tick($urandom_range(1, 3));
          number = old_num;
        end
      endcase
      tick($urandom_range(0, 200));
    end
    wait_quiet("rand_end");

    chk_int("pending_writes", q0.size() + q1.size(), 0);
    chk_int("pending_done", dq0.size() + dq1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
